fwd_bypass_unit: RTL
====================

// Module: fwd_bypass_unit
// PURPOSE
//  Parametrised operand-forwarding unit for the RV32 pipeline; replaces the fixed 3-input EX forwarding mux.
//  Per source operand, selects regfile / EX / MEM / WB / WB-history data by youngest-match priority.
//  Flags load-use hazards and keeps a short WB history so regfile write-then-read latency needs no stall.
//  Sits at the ID/EX boundary, driven by hazard-tracking fields of the EX, MEM and WB pipeline registers.
// PARAMETERS
//  DATAWIDTH   32  operand / result width
//  NUM_SRC     2   number of source operands served (rs1, rs2, ...)
//  REGADDR_W   5   register address width
//  HIST_DEPTH  2   retired-WB history entries, legal range 1..4
// PORTS
//  clk             in   1                     clock, rising edge
//  rst             in   1                     synchronous reset, active-high
//  stall_in        in   1                     pipeline hold; freezes history and registered outputs
//  src_addr        in   NUM_SRC*REGADDR_W     source register indices, src k at [k*REGADDR_W +: REGADDR_W]
//  src_rdata       in   NUM_SRC*DATAWIDTH     regfile read data per source
//  ex_wen          in   1                     EX instruction writes rd
//  ex_is_load      in   1                     EX instruction is a load (data not yet available)
//  ex_rd           in   REGADDR_W             EX destination register
//  ex_data         in   DATAWIDTH             EX ALU result
//  mem_wen         in   1                     MEM instruction writes rd
//  mem_rd          in   REGADDR_W             MEM destination register
//  mem_data        in   DATAWIDTH             MEM result (ALU or load data)
//  wb_wen          in   1                     WB writes rd this cycle
//  wb_rd           in   REGADDR_W             WB destination register
//  wb_data         in   DATAWIDTH             WB write data
//  operand_out     out  NUM_SRC*DATAWIDTH     forwarded operand per source
//  fwd_sel         out  NUM_SRC*3             source code: 0 regfile, 1 EX, 2 MEM, 3 WB, 4+k history entry k
//  load_use_stall  out  1                     load-use hazard on any source
//  lu_stall_cnt    out  16                    saturating count of load_use_stall cycles
// BEHAVIOUR
//  - Priority per source (youngest first): EX > MEM > WB > hist[0] (youngest) .. hist[HIST_DEPTH-1] > regfile.
//  - Stage matches only if its wen=1, its rd == src_addr, and src_addr != 0; x0 is never forwarded, always regfile data.
//  - EX match with ex_is_load=1: operand is don't-care, fwd_sel=1, load_use_stall=1 (OR over all sources).
//  - History: shift register of {valid, rd, data}. On each clk with rst=0 and stall_in=0:
//    hist[0] <= {wb_wen & (wb_rd!=0), wb_rd, wb_data}; hist[i] <= hist[i-1]; oldest entry dropped.
//  - stall_in=1: history and counter hold; combinational outputs still track inputs.
//  - lu_stall_cnt: +1 each clk where load_use_stall=1 and stall_in=0; saturates at 16'hFFFF, no wrap.
//  - rst=1 (synchronous, any time incl. mid-hazard): all hist valid=0, lu_stall_cnt=0;
//    registered outputs (if any) = 0; rst dominates stall_in.
//  - Simultaneous equal rd in several stages/entries: only the highest-priority match is used.
//  - Default latency: operand_out, fwd_sel, load_use_stall combinational from inputs + history state.
// CONFIGURATION
//  Macro FWD_OPERAND_REG_EN:
//   defined: operand_out and fwd_sel are registered; one-cycle latency; register reloads when stall_in=0,
//            holds when stall_in=1; reset value 0. load_use_stall stays combinational.
//   undefined: operand_out and fwd_sel are purely combinational (zero latency).
// TESTING (defaults, macro undefined unless stated)
//  1. rst=1 for 2 clk, src_rdata=0x11 -> operand_out=0x11, fwd_sel=0, lu_stall_cnt=0, no history hits.
//  2. ex/mem both wen, rd=5, ex_data=0xA, mem_data=0xB, src0=5 -> operand0=0xA, sel0=1; drop ex_wen -> 0xB, sel=2.
//  3. ex_wen=1, ex_rd=0, ex_data=0xFF, src0=0, src_rdata=0 -> operand0=0, sel0=0.
//  4. wb writes x7=0xDEADBEEF at cycle n; src0=7, regfile=0 from n+1 -> operand0=0xDEADBEEF, sel0=4 (n+1), 5 (n+2), 0 (n+3).
//  5. ex_is_load, ex_rd=3, src1=3 for 3 clk -> load_use_stall=1, lu_stall_cnt=3; preload 16'hFFFE, 3 clk -> 16'hFFFF.
//  6. stall_in=1 for 3 clk after WB x9 write -> hist[0] holds x9, sel=4 throughout; with FWD_OPERAND_REG_EN, sel0 updates 1 clk after input change.

Source files
------------

// File: rtl/fwd_bypass_unit.sv
// fwd_bypass_unit
//   Operand-forwarding unit at the ID/EX boundary. For each source operand it
//   picks the youngest in-flight producer: EX, then MEM, then WB, then the
//   retired-WB history (youngest first), and finally regfile data.
//   It flags load-use hazards and counts stall cycles with a saturating counter.
//   The WB history covers the regfile write-then-read window, so that window
//   needs no stall.
//   Optional build macro: FWD_OPERAND_REG_EN registers operand_out/fwd_sel
//   (one-cycle latency, hold on stall_in, reset to 0).
module fwd_bypass_unit #(
  parameter int DATAWIDTH  = 32,
  parameter int NUM_SRC    = 2,
  parameter int REGADDR_W  = 5,
  parameter int HIST_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall_in,
  input  logic [NUM_SRC*REGADDR_W-1:0]   src_addr,
  input  logic [NUM_SRC*DATAWIDTH-1:0]   src_rdata,
  input  logic                           ex_wen,
  input  logic                           ex_is_load,
  input  logic [REGADDR_W-1:0]           ex_rd,
  input  logic [DATAWIDTH-1:0]           ex_data,
  input  logic                           mem_wen,
  input  logic [REGADDR_W-1:0]           mem_rd,
  input  logic [DATAWIDTH-1:0]           mem_data,
  input  logic                           wb_wen,
  input  logic [REGADDR_W-1:0]           wb_rd,
  input  logic [DATAWIDTH-1:0]           wb_data,
  output logic [NUM_SRC*DATAWIDTH-1:0]   operand_out,
  output logic [NUM_SRC*3-1:0]           fwd_sel,
  output logic                           load_use_stall,
  output logic [15:0]                    lu_stall_cnt
);

  localparam logic [2:0] SEL_RF  = 3'd0;
  localparam logic [2:0] SEL_EX  = 3'd1;
  localparam logic [2:0] SEL_MEM = 3'd2;
  localparam logic [2:0] SEL_WB  = 3'd3;

  // Retired-WB history; entry 0 is the most recently retired write.
  logic                 hist_valid_reg [HIST_DEPTH];
  logic [REGADDR_W-1:0] hist_rd_reg    [HIST_DEPTH];
  logic [DATAWIDTH-1:0] hist_data_reg  [HIST_DEPTH];

  logic [NUM_SRC-1:0]   lu_vec;
  logic [15:0]          lu_cnt_reg;

  genvar gi;

  // History shift register: capture WB into entry 0, age the rest, drop the oldest.
  generate
    for (gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
      if (gi == 0) begin : g_head
        // Load the head entry from this cycle's WB write (x0 writes are never valid).
        always_ff @(posedge clk) begin
          if (rst) begin
            hist_valid_reg[0] <= 1'b0;
            hist_rd_reg[0]    <= '0;
            hist_data_reg[0]  <= '0;
          end else if (!stall_in) begin
            hist_valid_reg[0] <= wb_wen && (wb_rd != '0);
            hist_rd_reg[0]    <= wb_rd;
            hist_data_reg[0]  <= wb_data;
          end
        end
      end else begin : g_tail
        // Age the entry by copying from the next-younger slot.
        always_ff @(posedge clk) begin
          if (rst) begin
            hist_valid_reg[gi] <= 1'b0;
            hist_rd_reg[gi]    <= '0;
            hist_data_reg[gi]  <= '0;
          end else if (!stall_in) begin
            hist_valid_reg[gi] <= hist_valid_reg[gi-1];
            hist_rd_reg[gi]    <= hist_rd_reg[gi-1];
            hist_data_reg[gi]  <= hist_data_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // Per-source priority select and load-use detection.
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REGADDR_W-1:0] addr_w;
      logic [DATAWIDTH-1:0] rf_w;
      logic [DATAWIDTH-1:0] data_next;
      logic [2:0]           sel_next;

      assign addr_w = src_addr[gi*REGADDR_W +: REGADDR_W];
      assign rf_w   = src_rdata[gi*DATAWIDTH +: DATAWIDTH];

      // Walk producers from oldest to youngest so the youngest match overrides.
      always_comb begin
        sel_next  = SEL_RF;
        data_next = rf_w;
        if (addr_w != '0) begin
          for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
            if (hist_valid_reg[i] && (hist_rd_reg[i] == addr_w)) begin
              sel_next  = 3'(4 + i);
              data_next = hist_data_reg[i];
            end
          end
          if (wb_wen && (wb_rd == addr_w)) begin
            sel_next  = SEL_WB;
            data_next = wb_data;
          end
          if (mem_wen && (mem_rd == addr_w)) begin
            sel_next  = SEL_MEM;
            data_next = mem_data;
          end
          if (ex_wen && (ex_rd == addr_w)) begin
            sel_next  = SEL_EX;
            data_next = ex_data;
          end
        end
      end

      assign lu_vec[gi] = ex_wen && ex_is_load && (addr_w != '0) && (ex_rd == addr_w);

`ifdef FWD_OPERAND_REG_EN
      logic [DATAWIDTH-1:0] data_reg;
      logic [2:0]           sel_reg;

      // Registered operand path; holds while the pipeline is stalled.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
          sel_reg  <= '0;
        end else if (!stall_in) begin
          data_reg <= data_next;
          sel_reg  <= sel_next;
        end
      end

      assign operand_out[gi*DATAWIDTH +: DATAWIDTH] = data_reg;
      assign fwd_sel[gi*3 +: 3]                     = sel_reg;
`else
      assign operand_out[gi*DATAWIDTH +: DATAWIDTH] = data_next;
      assign fwd_sel[gi*3 +: 3]                     = sel_next;
`endif
    end
  endgenerate

  assign load_use_stall = |lu_vec;

  // Saturating count of load-use stall cycles taken while the pipeline advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_reg <= '0;
    end else if (!stall_in && load_use_stall && (lu_cnt_reg != 16'hFFFF)) begin
      lu_cnt_reg <= lu_cnt_reg + 16'd1;
    end
  end

  assign lu_stall_cnt = lu_cnt_reg;

endmodule
